// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller.
// Takes one signed operand pair per handshake. Each cycle it performs one
// Booth recoding step on a shared add/subtract datapath, then holds the
// signed product until the consumer takes it.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for operands; in_ready high; result keeps last product
// ST_RUN  | one Booth step per cycle, WIDTH steps in total
// ST_DONE | product valid on result/nz_ops; waiting for out_ready
module booth_seq_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op_1,
  input  logic [WIDTH-1:0]     op_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [CNT_W-1:0]     nz_ops,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand is kept pre-shifted so step i adds op_1ext << i without
  // a variable shifter.
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  // {op_2, 1'b0} shifted right each step; bits [1:0] are the current Booth pair.
  logic [WIDTH:0]       mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     nz_q, nz_d;

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    nz_d      = nz_q;
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{op_1[WIDTH-1]}}, op_1};
          mplier_d = {op_2, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          nz_d     = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        case (mplier_q[1:0])
          2'b10: begin
            acc_d = acc_q - mcand_q;
            nz_d  = nz_q + CNT_ONE;
          end
          2'b01: begin
            acc_d = acc_q + mcand_q;
            nz_d  = nz_q + CNT_ONE;
          end
          default: acc_d = acc_q;
        endcase
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      nz_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      nz_q     <= nz_d;
    end
  end

  assign result = acc_q;
  assign nz_ops = nz_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and random checks for booth_seq_ctrl at WIDTH=8.
module tb_booth_seq_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    op_1;
  logic [W-1:0]    op_2;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  result;
  logic [CW-1:0]   nz_ops;
  logic            busy;

  int total = 0;
  int bad   = 0;

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_1      (op_1),
    .op_2      (op_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .nz_ops    (nz_ops),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_res;
    int             exp_nz;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents the pair for exactly one edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      ok = 1'b0;
      return;
    end
    in_valid = 1'b1;
    op_1     = a;
    op_2     = b;
    tick();
    in_valid = 1'b0;
    op_1     = W'($urandom);
    op_2     = W'($urandom);
    ok       = 1'b1;
  endtask

  // Full operation with out_ready held high; checks exact latency.
  task automatic run_fixed(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp_res, input int exp_nz);
    bit ok;
    out_ready = 1'b1;
    start_op(a, b, ok);
    if (!ok) return;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_in_run", 32'(in_ready), 32'd0);
    repeat (W - 1) tick();
    chk("no_early_valid", 32'(out_valid), 32'd0);
    tick();
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("result", 32'(result), 32'(exp_res));
    chk("nz_ops", 32'(nz_ops), 32'(exp_nz));
    tick();
    chk("valid_dropped", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  function automatic int ref_nz(input logic [W-1:0] b);
    int   n;
    logic prev;
    n    = 0;
    prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (b[i] != prev) n++;
      prev = b[i];
    end
    return n;
  endfunction

  initial begin
    bit ok;
    bit seen;

    vecs[0] = '{8'h03, 8'h05, 16'h000F, 4};
    vecs[1] = '{8'hFD, 8'h05, 16'hFFF1, 4};
    vecs[2] = '{8'h07, 8'hFF, 16'hFFF9, 1};
    vecs[3] = '{8'h80, 8'h80, 16'h4000, 1};
    vecs[4] = '{8'h00, 8'h5A, 16'h0000, 6};
    vecs[5] = '{8'h7F, 8'h80, 16'hC080, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_1 = '0; op_2 = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_nz", 32'(nz_ops), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_fixed(vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_nz);
    end

    // Back-pressure in DONE with in_valid asserted and operands moving.
    out_ready = 1'b0;
    start_op(8'h03, 8'h05, ok);
    repeat (W) tick();
    chk("bp_valid_first", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      op_1 = W'($urandom);
      op_2 = W'($urandom);
      tick();
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_result_hold", 32'(result), 32'h000F);
      chk("bp_nz_hold", 32'(nz_ops), 32'd4);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of RUN discards the operation.
    out_ready = 1'b1;
    start_op(8'h07, 8'hFF, ok);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_nz", 32'(nz_ops), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("midrst_no_pulse", 32'(seen), 32'd0);
    run_fixed(8'h03, 8'h05, 16'h000F, 4);

    // Random operands with random consumer stalls.
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] a, b;
      int stall;
      a = W'($urandom);
      b = W'($urandom);
      out_ready = 1'b0;
      start_op(a, b, ok);
      if (!ok) break;
      repeat (W) tick();
      chk("rnd_valid", 32'(out_valid), 32'd1);
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        in_valid = $urandom_range(0, 1);
        tick();
      end
      in_valid = 1'b0;
      chk("rnd_result", 32'(result), 32'(ref_prod(a, b)));
      chk("rnd_nz", 32'(nz_ops), 32'(ref_nz(b)));
      out_ready = 1'b1;
      tick();
      chk("rnd_consumed", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
